// File: rtl/jtdd_snd_mixer.sv
// jtdd_snd_mixer: FM + ADPCM output mixer with per-source gain, 16-bit
// saturation, an optional one-pole low-pass and a strobed stereo output.
// A single signed multiplier is shared over the ML/MR/MP sequencer states.
module jtdd_snd_mixer #(
  parameter int FRAC  = 4,
  parameter int OVR_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [15:0]      fm_left,
  input  logic signed [15:0]      fm_right,
  input  logic                    fm_sample,
  input  logic signed [11:0]      adpcm0,
  input  logic signed [11:0]      adpcm1,
  input  logic        [7:0]       gain_fm,
  input  logic        [7:0]       gain_pcm,
  input  logic                    lpf_en,
  input  logic        [1:0]       lpf_sh,
  input  logic                    clip_clr,
  output logic signed [15:0]      left,
  output logic signed [15:0]      right,
  output logic                    sample,
  output logic                    clip,
  output logic        [OVR_W-1:0] overrun
);

  typedef enum logic [2:0] {IDLE, ML, MR, MP, SAT, FLT, OUT} state_t;

  state_t state, state_nxt;
  logic   prev, req, start, pending;

  logic signed [15:0] cap_left, cap_right;
  logic signed [16:0] cap_pcm;
  logic        [7:0]  cap_gfm, cap_gpcm;
  logic signed [25:0] pl, pr, pp, prod;
  logic signed [16:0] mul_a;
  logic signed [8:0]  mul_b;
  logic signed [12:0] pcm_sum;
  logic signed [15:0] sl, sr, yl, yr, yl_nxt, yr_nxt;
  logic signed [26:0] sum_l, sum_r;
  logic        [16:0] sat_l, sat_r;
  logic        [2:0]  shamt;

  assign req     = fm_sample & ~prev;
  assign pcm_sum = 13'(adpcm0) + 13'(adpcm1);
  assign shamt   = {1'b0, lpf_sh} + 3'd1;

  // Clamp a wide sum to 16 bits; bit 16 of the result flags that clamping happened.
  function automatic logic [16:0] clamp16(input logic signed [26:0] v);
    if (v > 27'sd32767)       return {1'b1, 16'h7fff};
    else if (v < -27'sd32768) return {1'b1, 16'h8000};
    else                      return {1'b0, v[15:0]};
  endfunction

  // One low-pass step; in bypass the state follows the input so enabling is glitch-free.
  function automatic logic signed [15:0] lpf_step(input logic signed [15:0] x,
                                                  input logic signed [15:0] y,
                                                  input logic en,
                                                  input logic [2:0] sh);
    logic signed [16:0] diff, acc;
    diff = 17'(x) - 17'(y);
    acc  = 17'(y) + (diff >>> sh);
    return en ? acc[15:0] : x;
  endfunction

  // Previous fm_sample; resets high so a level held through reset is not a new edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= fm_sample;
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: one state per clock; OUT chains straight into a queued or fresh mix.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: if (req) begin state_nxt = ML; start = 1'b1; end
      ML:   state_nxt = MR;
      MR:   state_nxt = MP;
      MP:   state_nxt = SAT;
      SAT:  state_nxt = FLT;
      FLT:  state_nxt = OUT;
      OUT:  begin
        if (pending || req) begin state_nxt = ML; start = 1'b1; end
        else                 state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Queue one request that arrives mid-mix; count further ones as dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      overrun <= '0;
    end else if (state == OUT) begin
      pending <= pending & req;
    end else if (state != IDLE && req) begin
      if (!pending)             pending <= 1'b1;
      else if (overrun != '1)   overrun <= overrun + OVR_W'(1);
    end
  end

  // Shared multiplier: signed sample times zero-extended gain.
  always_comb begin
    mul_a = 17'(cap_pcm);
    mul_b = {1'b0, cap_gpcm};
    case (state)
      ML:      begin mul_a = 17'(cap_left);  mul_b = {1'b0, cap_gfm}; end
      MR:      begin mul_a = 17'(cap_right); mul_b = {1'b0, cap_gfm}; end
      default: ;
    endcase
    prod  = 26'(mul_a) * 26'(mul_b);
    sum_l = (27'(pl) + 27'(pp)) >>> FRAC;
    sum_r = (27'(pr) + 27'(pp)) >>> FRAC;
    sat_l = clamp16(sum_l);
    sat_r = clamp16(sum_r);
    yl_nxt = lpf_step(sl, yl, lpf_en, shamt);
    yr_nxt = lpf_step(sr, yr, lpf_en, shamt);
  end

  // Datapath: capture, products, saturation, filter; outputs load in FLT so they
  // are already valid during the OUT cycle that carries the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_left <= '0; cap_right <= '0; cap_pcm <= '0;
      cap_gfm  <= '0; cap_gpcm  <= '0;
      pl <= '0; pr <= '0; pp <= '0;
      sl <= '0; sr <= '0; yl <= '0; yr <= '0;
      left <= '0; right <= '0; sample <= 1'b0; clip <= 1'b0;
    end else begin
      sample <= (state == FLT);
      if (start) begin
        cap_left  <= fm_left;
        cap_right <= fm_right;
        cap_pcm   <= {pcm_sum, 4'b0000};
        cap_gfm   <= gain_fm;
        cap_gpcm  <= gain_pcm;
      end
      case (state)
        ML:  pl <= prod;
        MR:  pr <= prod;
        MP:  pp <= prod;
        SAT: begin sl <= sat_l[15:0]; sr <= sat_r[15:0]; end
        FLT: begin
          yl <= yl_nxt; yr <= yr_nxt;
          left <= yl_nxt; right <= yr_nxt;
        end
        default: ;
      endcase
      if (state == SAT && (sat_l[16] || sat_r[16])) clip <= 1'b1;
      else if (clip_clr)                             clip <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtdd_snd_mixer.sv
// Testbench for jtdd_snd_mixer: directed spec cases plus randomized mixes
// compared against an arithmetic reference model.
module tb_jtdd_snd_mixer;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [15:0] fm_left = '0, fm_right = '0;
  logic               fm_sample = 1'b0;
  logic signed [11:0] adpcm0 = '0, adpcm1 = '0;
  logic        [7:0]  gain_fm = '0, gain_pcm = '0;
  logic               lpf_en = 1'b0;
  logic        [1:0]  lpf_sh = '0;
  logic               clip_clr = 1'b0;
  logic signed [15:0] left, right;
  logic               sample, clip;
  logic        [7:0]  overrun;

  int checks = 0;
  int failures = 0;
  int ml_y = 0, mr_y = 0, m_l = 0, m_r = 0;
  logic m_clip = 1'b0;

  jtdd_snd_mixer #(.FRAC(4), .OVR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .fm_left(fm_left), .fm_right(fm_right),
    .fm_sample(fm_sample), .adpcm0(adpcm0), .adpcm1(adpcm1),
    .gain_fm(gain_fm), .gain_pcm(gain_pcm), .lpf_en(lpf_en), .lpf_sh(lpf_sh),
    .clip_clr(clip_clr), .left(left), .right(right), .sample(sample),
    .clip(clip), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int clampv(input int v, inout logic hit);
    if (v > 32767)  begin hit = 1'b1; return 32767;  end
    if (v < -32768) begin hit = 1'b1; return -32768; end
    return v;
  endfunction

  // Reference: gain products in plain integers, floor-divide by 16, clamp, then filter.
  task automatic model_mix(input int fl, input int fr, input int a0, input int a1,
                           input int gf, input int gp, input int en, input int sh);
    int pp, xl, xr;
    logic hit;
    hit = 1'b0;
    pp = (a0 + a1) * 16 * gp;
    xl = clampv((fl * gf + pp) >>> 4, hit);
    xr = clampv((fr * gf + pp) >>> 4, hit);
    if (en != 0) begin
      ml_y = ml_y + ((xl - ml_y) >>> (sh + 1));
      mr_y = mr_y + ((xr - mr_y) >>> (sh + 1));
    end else begin
      ml_y = xl;
      mr_y = xr;
    end
    m_l = ml_y;
    m_r = mr_y;
    if (hit) m_clip = 1'b1;
  endtask

  task automatic applyStimulus(input int fl, input int fr, input int a0, input int a1,
                               input int gf, input int gp, input int en, input int sh);
    fm_left = 16'(fl); fm_right = 16'(fr);
    adpcm0 = 12'(a0);  adpcm1 = 12'(a1);
    gain_fm = 8'(gf);  gain_pcm = 8'(gp);
    lpf_en = en[0];    lpf_sh = 2'(sh);
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_left"}, 32'(left), m_l);
    check({tag, "_right"}, 32'(right), m_r);
    check({tag, "_clip"}, 32'(clip), 32'(m_clip));
  endtask

  // One complete mix: edge in the current cycle, strobe expected 6 cycles later.
  task automatic run_mix(input string tag, input int fl, input int fr, input int a0,
                         input int a1, input int gf, input int gp, input int en,
                         input int sh);
    int n;
    applyStimulus(fl, fr, a0, a1, gf, gp, en, sh);
    model_mix(fl, fr, a0, a1, gf, gp, en, sh);
    fm_sample = 1'b1;
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 1) fm_sample = 1'b0;
      if (sample === 1'b1) begin n = i; break; end
    end
    check({tag, "_latency"}, n, 6);
    checkOutput(tag);
    tick();
    check({tag, "_strobe_len"}, 32'(sample), 0);
  endtask

  task automatic clear_clip();
    clip_clr = 1'b1; tick(); clip_clr = 1'b0;
    m_clip = 1'b0;
    check("clip_clr", 32'(clip), 0);
  endtask

  initial begin
    int s1, s2, ns;
    $display("[TB] start");
    repeat (3) tick();
    check("rst_left", 32'(left), 0);
    check("rst_right", 32'(right), 0);
    check("rst_sample", 32'(sample), 0);
    check("rst_clip", 32'(clip), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    run_mix("unity", 1000, -1000, 0, 0, 16, 0, 0, 0);
    check("unity_left_const", 32'(left), 1000);

    run_mix("fm_clip", 30000, 0, 0, 0, 32, 0, 0, 0);
    check("fm_clip_const", 32'(left), 32767);
    clear_clip();

    run_mix("pcm_clip", 0, 0, -2048, -2048, 16, 16, 0, 0);
    check("pcm_clip_const", 32'(right), -32768);
    clear_clip();

    run_mix("lpf_zero", 0, 0, 0, 0, 16, 16, 0, 0);
    run_mix("lpf_s1", 16000, 16000, 0, 0, 16, 16, 1, 0);
    check("lpf_s1_const", 32'(left), 8000);
    run_mix("lpf_s2", 16000, 16000, 0, 0, 16, 16, 1, 0);
    check("lpf_s2_const", 32'(left), 12000);
    run_mix("lpf_s3", 16000, 16000, 0, 0, 16, 16, 1, 0);
    check("lpf_s3_const", 32'(left), 14000);

    for (int it = 0; it < 24; it++) begin
      int fl, fr, a0, a1;
      fl = int'($signed(16'($urandom)));
      fr = int'($signed(16'($urandom)));
      a0 = int'($signed(12'($urandom)));
      a1 = int'($signed(12'($urandom)));
      if (it % 4 == 0) clear_clip();
      run_mix("rand", fl, fr, a0, a1, int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)));
    end

    // Three edges two cycles apart: one queued, one dropped.
    applyStimulus(500, -700, 0, 0, 16, 0, 0, 0);
    model_mix(500, -700, 0, 0, 16, 0, 0, 0);
    model_mix(500, -700, 0, 0, 16, 0, 0, 0);
    s1 = 0; s2 = 0; ns = 0;
    fm_sample = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      fm_sample = (i == 2 || i == 4);
      if (sample === 1'b1) begin
        ns++;
        if (s1 == 0) s1 = i; else s2 = i;
      end
    end
    check("burst_count", ns, 2);
    check("burst_first", s1, 6);
    check("burst_second", s2, 12);
    check("burst_overrun", 32'(overrun), 1);
    check("burst_left", 32'(left), m_l);

    // Reset in the middle of a mix.
    applyStimulus(1234, 4321, 0, 0, 16, 0, 0, 0);
    fm_sample = 1'b1;
    tick(); fm_sample = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("midrst_left", 32'(left), 0);
    check("midrst_overrun", 32'(overrun), 0);
    tick();
    rst_n = 1'b1;
    ml_y = 0; mr_y = 0; m_clip = 1'b0;
    ns = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (sample === 1'b1) ns++;
    end
    check("midrst_no_strobe", ns, 0);
    run_mix("post_rst", 1234, 4321, 100, -50, 16, 32, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
